mem_stage: RTL and testbench

//  MEM pipeline stage. Consumes the registered EX/MEM bundle (ALU result, zero, overflow,

---
 rtl/mem_stage_pkg.sv | 20 ++
 rtl/mem_stage_load_align.sv | 33 +++
 rtl/mem_stage.sv | 214 +++++++++++++++++++++
 tb/tb_mem_stage.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: default widths, the
// two-state cache handshake encoding and the byte-lane enable helper.
package mem_stage_pkg;

  localparam int DEF_REG_SIZE  = 32;
  localparam int DEF_ADDR_SIZE = 32;
  localparam int DEF_REG_ADDR  = 5;

  // 1-bit state encoding: idle / waiting on the data cache
  typedef enum logic {
    MEM_IDLE = 1'b0,
    MEM_WAIT = 1'b1
  } mem_state_e;

  // One-hot byte enable for the lane addressed by the low address bits
  function automatic logic [3:0] byte_lane_be(input logic [1:0] lane);
    return 4'b0001 << lane;
  endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Load data alignment for byte accesses: picks the lane addressed by the
// low address bits and sign-extends it; word loads pass through.
module mem_stage_load_align
  import mem_stage_pkg::*;
#(
  parameter int REG_SIZE = DEF_REG_SIZE
) (
  input  logic [REG_SIZE-1:0] rdata,
  input  logic [1:0]          lane,
  input  logic                byte_sel,
  output logic [REG_SIZE-1:0] data
);

  logic [7:0] lane_byte_s;

  // Select the addressed byte lane and sign-extend it for byte loads
  always_comb begin
    lane_byte_s = 8'h00;
    case (lane)
      2'b00:   lane_byte_s = rdata[7:0];
      2'b01:   lane_byte_s = rdata[15:8];
      2'b10:   lane_byte_s = rdata[23:16];
      2'b11:   lane_byte_s = rdata[31:24];
      default: lane_byte_s = rdata[7:0];
    endcase
    if (byte_sel) begin
      data = {{(REG_SIZE-8){lane_byte_s[7]}}, lane_byte_s};
    end else begin
      data = rdata;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: branch resolution, req/ack data-cache access with
// upstream stall, and the registered MEM/WB bundle.
// Optional feature macro: MEM_BYTE_ACCESS_EN (byte loads/stores).
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int REG_SIZE  = DEF_REG_SIZE,
  parameter int ADDR_SIZE = DEF_ADDR_SIZE,
  parameter int REG_ADDR  = DEF_REG_ADDR
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 regwrite_in,
  input  logic                 memread,
  input  logic                 memwrite,
  input  logic                 memtoreg,
  input  logic                 branch,
  input  logic                 zero,
  input  logic                 overflow,
  input  logic                 byte_op,
  input  logic [REG_SIZE-1:0]  aluresult,
  input  logic [REG_SIZE-1:0]  store_data,
  input  logic [ADDR_SIZE-1:0] pc_branch,
  input  logic [REG_ADDR-1:0]  wreg_in,
  output logic                 pc_src,
  output logic [ADDR_SIZE-1:0] pc_target,
  output logic                 stall,
  output logic                 dc_req,
  output logic                 dc_we,
  output logic [ADDR_SIZE-1:0] dc_addr,
  output logic [REG_SIZE-1:0]  dc_wdata,
  output logic [3:0]           dc_be,
  input  logic                 dc_ack,
  input  logic [REG_SIZE-1:0]  dc_rdata,
  output logic                 regwrite_out,
  output logic [REG_SIZE-1:0]  wb_data,
  output logic [REG_ADDR-1:0]  wreg_out,
  output logic                 ovf_trap
);

  mem_state_e            state_r;
  mem_state_e            state_nxt_s;
  logic                  memop_s;
  logic                  stall_s;
  logic                  capture_s;
  logic                  complete_s;
  logic                  bubble_s;
  logic [REG_SIZE-1:0]   wb_data_nxt_s;
  logic [REG_SIZE-1:0]   load_data_s;
  logic [ADDR_SIZE-1:0]  dc_addr_nxt_s;
  logic [REG_SIZE-1:0]   dc_wdata_nxt_s;
  logic [3:0]            dc_be_nxt_s;

  logic                  dc_req_r;
  logic                  dc_we_r;
  logic [ADDR_SIZE-1:0]  dc_addr_r;
  logic [REG_SIZE-1:0]   dc_wdata_r;
  logic [3:0]            dc_be_r;
  logic                  regwrite_out_r;
  logic [REG_SIZE-1:0]   wb_data_r;
  logic [REG_ADDR-1:0]   wreg_out_r;
  logic                  ovf_trap_r;

  // A load wins when both read and write are requested
  assign memop_s = memread | memwrite;

  // State register: reset abandons any outstanding cache request
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= MEM_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state: issue on a memop, return to idle on the cache ack
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      MEM_IDLE: begin
        if (memop_s) state_nxt_s = MEM_WAIT;
        else         state_nxt_s = MEM_IDLE;
      end
      MEM_WAIT: begin
        if (dc_ack) state_nxt_s = MEM_IDLE;
        else        state_nxt_s = MEM_WAIT;
      end
      default: state_nxt_s = MEM_IDLE;
    endcase
  end

  // Stage control: stall, request capture, MEM/WB completion or bubble
  always_comb begin
    stall_s       = 1'b0;
    capture_s     = 1'b0;
    complete_s    = 1'b0;
    bubble_s      = 1'b0;
    wb_data_nxt_s = aluresult;
    case (state_r)
      MEM_IDLE: begin
        if (memop_s) begin
          stall_s   = 1'b1;
          capture_s = 1'b1;
          bubble_s  = 1'b1;
        end else begin
          complete_s = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (dc_ack) begin
          complete_s = 1'b1;
          if (memtoreg) wb_data_nxt_s = load_data_s;
          else          wb_data_nxt_s = aluresult;
        end else begin
          stall_s  = 1'b1;
          bubble_s = 1'b1;
        end
      end
      default: begin
        stall_s = 1'b0;
      end
    endcase
  end

  // Cache request fields presented on the issue edge
  always_comb begin
    dc_addr_nxt_s  = aluresult[ADDR_SIZE-1:0];
    dc_wdata_nxt_s = store_data;
    dc_be_nxt_s    = 4'b1111;
`ifdef MEM_BYTE_ACCESS_EN
    if (byte_op) begin
      dc_be_nxt_s    = byte_lane_be(aluresult[1:0]);
      dc_wdata_nxt_s = {(REG_SIZE/8){store_data[7:0]}};
    end else begin
      dc_be_nxt_s    = 4'b1111;
      dc_wdata_nxt_s = store_data;
    end
`else
    dc_addr_nxt_s[1:0] = 2'b00;
`endif
  end

`ifdef MEM_BYTE_ACCESS_EN
  logic byte_r;

  // Remember whether the outstanding request is a byte access
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_r <= 1'b0;
    end else if (capture_s) begin
      byte_r <= byte_op;
    end
  end

  mem_stage_load_align #(
    .REG_SIZE (REG_SIZE)
  ) u_load_align (
    .rdata    (dc_rdata),
    .lane     (dc_addr_r[1:0]),
    .byte_sel (byte_r),
    .data     (load_data_s)
  );
`else
  logic unused_byte_op_s;
  assign unused_byte_op_s = byte_op;
  assign load_data_s      = dc_rdata;
`endif

  // Cache port registers and the MEM/WB bundle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dc_req_r       <= 1'b0;
      dc_we_r        <= 1'b0;
      dc_addr_r      <= '0;
      dc_wdata_r     <= '0;
      dc_be_r        <= 4'b0000;
      regwrite_out_r <= 1'b0;
      wb_data_r      <= '0;
      wreg_out_r     <= '0;
      ovf_trap_r     <= 1'b0;
    end else begin
      dc_req_r <= (state_nxt_s == MEM_WAIT);
      if (capture_s) begin
        dc_we_r    <= memwrite & ~memread;
        dc_addr_r  <= dc_addr_nxt_s;
        dc_wdata_r <= dc_wdata_nxt_s;
        dc_be_r    <= dc_be_nxt_s;
      end
      if (complete_s) begin
        regwrite_out_r <= regwrite_in & ~overflow;
        ovf_trap_r     <= regwrite_in & overflow;
        wb_data_r      <= wb_data_nxt_s;
        wreg_out_r     <= wreg_in;
      end else if (bubble_s) begin
        regwrite_out_r <= 1'b0;
        ovf_trap_r     <= 1'b0;
      end
    end
  end

  assign stall        = stall_s;
  assign pc_src       = branch & zero & ~stall_s;
  assign pc_target    = pc_branch;
  assign dc_req       = dc_req_r;
  assign dc_we        = dc_we_r;
  assign dc_addr      = dc_addr_r;
  assign dc_wdata     = dc_wdata_r;
  assign dc_be        = dc_be_r;
  assign regwrite_out = regwrite_out_r;
  assign wb_data      = wb_data_r;
  assign wreg_out     = wreg_out_r;
  assign ovf_trap     = ovf_trap_r;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        regwrite_in, memread, memwrite, memtoreg;
  logic        branch, zero, overflow, byte_op;
  logic [31:0] aluresult, store_data, pc_branch;
  logic [4:0]  wreg_in;
  logic        pc_src, stall, dc_req, dc_we, dc_ack;
  logic [31:0] pc_target, dc_addr, dc_wdata, dc_rdata, wb_data;
  logic [3:0]  dc_be;
  logic        regwrite_out, ovf_trap;
  logic [4:0]  wreg_out;

  int checks = 0;
  int errors = 0;
  int stall_cycles;

  mem_stage dut (
    .clk          (clk),
    .reset        (reset),
    .regwrite_in  (regwrite_in),
    .memread      (memread),
    .memwrite     (memwrite),
    .memtoreg     (memtoreg),
    .branch       (branch),
    .zero         (zero),
    .overflow     (overflow),
    .byte_op      (byte_op),
    .aluresult    (aluresult),
    .store_data   (store_data),
    .pc_branch    (pc_branch),
    .wreg_in      (wreg_in),
    .pc_src       (pc_src),
    .pc_target    (pc_target),
    .stall        (stall),
    .dc_req       (dc_req),
    .dc_we        (dc_we),
    .dc_addr      (dc_addr),
    .dc_wdata     (dc_wdata),
    .dc_be        (dc_be),
    .dc_ack       (dc_ack),
    .dc_rdata     (dc_rdata),
    .regwrite_out (regwrite_out),
    .wb_data      (wb_data),
    .wreg_out     (wreg_out),
    .ovf_trap     (ovf_trap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    regwrite_in = 1'b0; memread = 1'b0; memwrite = 1'b0; memtoreg = 1'b0;
    branch = 1'b0; zero = 1'b0; overflow = 1'b0; byte_op = 1'b0;
    aluresult = 32'h0; store_data = 32'h0; pc_branch = 32'h0; wreg_in = 5'd0;
    dc_ack = 1'b0; dc_rdata = 32'h0;
  endtask

  initial begin
    quiet();
    reset = 1'b1;
    tick();
    tick();
    // Reset state
    chk("rst_dc_req", {31'b0, dc_req}, 32'h0);
    chk("rst_regwrite", {31'b0, regwrite_out}, 32'h0);
    chk("rst_wb_data", wb_data, 32'h0);
    chk("rst_wreg", {27'b0, wreg_out}, 32'h0);
    chk("rst_dc_be", {28'b0, dc_be}, 32'h0);
    chk("rst_ovf", {31'b0, ovf_trap}, 32'h0);
    reset = 1'b0;

    // 1. ALU op, one-cycle latency
    aluresult = 32'h1234; wreg_in = 5'd5; regwrite_in = 1'b1;
    #1 chk("alu_stall", {31'b0, stall}, 32'h0);
    tick();
    chk("alu_wb", wb_data, 32'h1234);
    chk("alu_wreg", {27'b0, wreg_out}, 32'd5);
    chk("alu_rw", {31'b0, regwrite_out}, 32'h1);

    // 4. Branch taken while not stalled
    quiet();
    branch = 1'b1; zero = 1'b1; pc_branch = 32'h200;
    #1 chk("br_src", {31'b0, pc_src}, 32'h1);
    chk("br_target", pc_target, 32'h200);

    // 2. Load, ack three cycles after dc_req; branch held to check suppression
    tick();
    memread = 1'b1; memtoreg = 1'b1; aluresult = 32'h100; wreg_in = 5'd7; regwrite_in = 1'b1;
    stall_cycles = 0;
    #1 chk("ld_br_stalled", {31'b0, pc_src}, 32'h0);
    if (stall) stall_cycles++;
    tick();
    chk("ld_req", {31'b0, dc_req}, 32'h1);
    chk("ld_addr", dc_addr, 32'h100);
    chk("ld_we", {31'b0, dc_we}, 32'h0);
    chk("ld_bubble0", {31'b0, regwrite_out}, 32'h0);
    for (int i = 0; i < 2; i++) begin
      if (stall) stall_cycles++;
      tick();
      chk("ld_bubble", {31'b0, regwrite_out}, 32'h0);
      chk("ld_req_held", {31'b0, dc_req}, 32'h1);
    end
    if (stall) stall_cycles++;
    tick();
    dc_ack = 1'b1; dc_rdata = 32'hDEADBEEF;
    #1 chk("ld_ack_stall", {31'b0, stall}, 32'h0);
    chk("ld_ack_br", {31'b0, pc_src}, 32'h1);
    chk("ld_stall_cycles", stall_cycles, 32'd4);
    tick();
    chk("ld_req_drop", {31'b0, dc_req}, 32'h0);
    chk("ld_wb", wb_data, 32'hDEADBEEF);
    chk("ld_wreg", {27'b0, wreg_out}, 32'd7);
    chk("ld_rw", {31'b0, regwrite_out}, 32'h1);

    // 3. Store, ack in first WAIT cycle, no write-back
    quiet();
    memwrite = 1'b1; aluresult = 32'h40; store_data = 32'hA5;
    #1 chk("st_stall", {31'b0, stall}, 32'h1);
    tick();
    chk("st_we", {31'b0, dc_we}, 32'h1);
    chk("st_wdata", dc_wdata, 32'hA5);
    chk("st_be", {28'b0, dc_be}, 32'hF);
    chk("st_addr", dc_addr, 32'h40);
    dc_ack = 1'b1;
    #1 chk("st_ack_stall", {31'b0, stall}, 32'h0);
    tick();
    chk("st_req_drop", {31'b0, dc_req}, 32'h0);
    chk("st_rw", {31'b0, regwrite_out}, 32'h0);

    // Read and write together: load wins
    quiet();
    memread = 1'b1; memwrite = 1'b1; aluresult = 32'h43;
    tick();
    chk("rw_we", {31'b0, dc_we}, 32'h0);
`ifdef MEM_BYTE_ACCESS_EN
    chk("rw_addr", dc_addr, 32'h43);
`else
    chk("rw_addr", dc_addr, 32'h40);
`endif
    dc_ack = 1'b1;
    tick();

    // dc_ack in IDLE ignored
    quiet();
    dc_ack = 1'b1;
    #1 chk("idle_ack_stall", {31'b0, stall}, 32'h0);
    tick();
    chk("idle_ack_req", {31'b0, dc_req}, 32'h0);

    // 5. Overflow suppresses the write
    quiet();
    overflow = 1'b1; regwrite_in = 1'b1; aluresult = 32'h77; wreg_in = 5'd3;
    tick();
    chk("ovf_rw", {31'b0, regwrite_out}, 32'h0);
    chk("ovf_trap", {31'b0, ovf_trap}, 32'h1);
    chk("ovf_wb", wb_data, 32'h77);
    overflow = 1'b0;
    tick();
    chk("ovf_clear", {31'b0, ovf_trap}, 32'h0);
    chk("ovf_rw_back", {31'b0, regwrite_out}, 32'h1);

    // Reset during WAIT drops the request asynchronously
    quiet();
    memread = 1'b1;
    tick();
    chk("rw_wait_req", {31'b0, dc_req}, 32'h1);
    dc_ack = 1'b1;
    #1 chk("rw_wait_stall", {31'b0, stall}, 32'h0);
    reset = 1'b1;
    #1 chk("async_req", {31'b0, dc_req}, 32'h0);
    chk("async_idle", {31'b0, stall}, 32'h1);
    reset = 1'b0;
    quiet();
    tick();

`ifdef MEM_BYTE_ACCESS_EN
    // 6. Byte load at lane 3, sign-extended
    memread = 1'b1; memtoreg = 1'b1; byte_op = 1'b1; aluresult = 32'h103;
    regwrite_in = 1'b1; wreg_in = 5'd9;
    tick();
    chk("bl_be", {28'b0, dc_be}, 32'h8);
    dc_ack = 1'b1; dc_rdata = 32'h80FFFFFF;
    tick();
    chk("bl_wb", wb_data, 32'hFFFFFF80);
    quiet();
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
